// File: rtl/a0_trace_buffer_if.sv
// Drain-side handshake bundle of the a0 trace buffer.
// With A0_TRACE_TIMESTAMP_EN defined, it also carries the head entry's capture stamp.
interface a0_trace_buffer_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 16
);
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
`ifdef A0_TRACE_TIMESTAMP_EN
  logic [CNT_WIDTH-1:0]  out_stamp;
`endif

  // Buffer side: drives head data and valid, receives ready.
  modport master (
    output out_data,
    output out_valid,
`ifdef A0_TRACE_TIMESTAMP_EN
    output out_stamp,
`endif
    input  out_ready
  );

  // Consumer side: receives head data and valid, drives ready.
  modport slave (
    input  out_data,
    input  out_valid,
`ifdef A0_TRACE_TIMESTAMP_EN
    input  out_stamp,
`endif
    output out_ready
  );
endinterface

// File: rtl/a0_trace_buffer.sv
// a0 trace buffer: captures every change of the CPU a0 register into a
// first-word-fall-through FIFO that is drained over a valid/ready link.
// Captures that find the FIFO full are dropped, and the drops are flagged
// and counted.
// Optional macro A0_TRACE_TIMESTAMP_EN stores a free-running cycle stamp
// with each entry and presents it as out_stamp.
module a0_trace_buffer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_WIDTH-1:0]  a0_in,
  input  logic                   cap_en,
  a0_trace_buffer_if.master      trace,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic [CNT_WIDTH-1:0]   drop_cnt,
  input  logic                   clr_ovf
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_WIDTH-1:0] prev_a0;
  logic [AW-1:0]         rd_ptr;
  logic [AW-1:0]         wr_ptr;
  logic                  valid;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  cap_c;
  logic                  pop_c;
  logic                  push_c;
  logic                  drop_c;
  logic [CW-1:0]         count_nxt_c;

  // Change detection and FIFO handshake decisions
  always_comb begin
    cap_c       = 1'b0;
    pop_c       = 1'b0;
    push_c      = 1'b0;
    drop_c      = 1'b0;
    count_nxt_c = count;
    cap_c  = cap_en && (a0_in != prev_a0);
    pop_c  = valid && trace.out_ready;
    push_c = cap_c && ((count < CW'(DEPTH)) || pop_c);
    drop_c = cap_c && !push_c;
    case ({push_c, pop_c})
      2'b10:   count_nxt_c = count + CW'(1);
      2'b01:   count_nxt_c = count - CW'(1);
      default: count_nxt_c = count;
    endcase
  end

  // Previous-a0 tracker, pointers, occupancy and valid flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_a0 <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      valid   <= 1'b0;
    end else begin
      prev_a0 <= a0_in;
      if (push_c) wr_ptr <= wr_ptr + AW'(1);
      if (pop_c)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt_c;
      valid <= (count_nxt_c != '0);
    end
  end

  // Drop flag and saturating drop counter; a drop overrides a same-cycle clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop_c) begin
      overflow <= 1'b1;
      if (clr_ovf)
        drop_cnt <= CNT_WIDTH'(1);
      else if (drop_cnt != '1)
        drop_cnt <= drop_cnt + CNT_WIDTH'(1);
    end else if (clr_ovf) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end
  end

  // Entry storage; contents need no reset because valid gates them
  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr] <= a0_in;
  end

  assign trace.out_data  = mem[rd_ptr];
  assign trace.out_valid = valid;

`ifdef A0_TRACE_TIMESTAMP_EN
  logic [CNT_WIDTH-1:0] cycle_cnt;
  logic [CNT_WIDTH-1:0] stamp_mem [DEPTH];

  // Free-running cycle counter used as the capture stamp
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cycle_cnt <= '0;
    else     cycle_cnt <= cycle_cnt + CNT_WIDTH'(1);
  end

  // Stamp storage written alongside the data entry
  always_ff @(posedge clk) begin
    if (push_c) stamp_mem[wr_ptr] <= cycle_cnt;
  end

  assign trace.out_stamp = stamp_mem[rd_ptr];
`endif

endmodule

// File: tb/tb_a0_trace_buffer.sv
// Directed bench for a0_trace_buffer: a vector table for single-cycle
// behaviour plus hand-written sequences for fill/overflow, full with
// simultaneous pop, clear versus drop, asynchronous reset, the capture-enable
// window and, when enabled, timestamps.
module tb_a0_trace_buffer;
  localparam int unsigned DW = 32;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned CNTW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] a0_in;
  logic          cap_en;
  logic [4:0]    count;
  logic          overflow;
  logic [CNTW-1:0] drop_cnt;
  logic          clr_ovf;

  int checks = 0;
  int failures = 0;

  a0_trace_buffer_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CNTW)) trace ();

  a0_trace_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CNTW)) dut (
    .clk      (clk),
    .rst      (rst),
    .a0_in    (a0_in),
    .cap_en   (cap_en),
    .trace    (trace),
    .count    (count),
    .overflow (overflow),
    .drop_cnt (drop_cnt),
    .clr_ovf  (clr_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] a0;
    logic          rdy;
    logic          exp_valid;
    logic [DW-1:0] exp_data;
    int            exp_count;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Apply current inputs across one rising edge, then settle
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    a0_in = '0;
    trace.out_ready = 1'b0;
    clr_ovf = 1'b0;
    cap_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] drain_exp [DEPTH];

    vecs[0]  = '{32'h5, 1'b0, 1'b1, 32'h5, 1};
    vecs[1]  = '{32'h5, 1'b1, 1'b0, 32'h0, 0};
    vecs[2]  = '{32'h5, 1'b0, 1'b0, 32'h0, 0};
    vecs[3]  = '{32'h7, 1'b1, 1'b1, 32'h7, 1};
    vecs[4]  = '{32'h9, 1'b0, 1'b1, 32'h7, 2};
    vecs[5]  = '{32'h9, 1'b0, 1'b1, 32'h7, 2};
    vecs[6]  = '{32'h3, 1'b1, 1'b1, 32'h9, 2};
    vecs[7]  = '{32'h3, 1'b1, 1'b1, 32'h3, 1};
    vecs[8]  = '{32'h3, 1'b1, 1'b0, 32'h0, 0};
    vecs[9]  = '{32'h0, 1'b0, 1'b1, 32'h0, 1};
    vecs[10] = '{32'h0, 1'b1, 1'b0, 32'h0, 0};

    do_reset();
    check("reset_count", 64'(count), 64'd0);
    check("reset_valid", 64'(trace.out_valid), 64'd0);
    check("reset_ovf", 64'(overflow), 64'd0);
    check("reset_drop", 64'(drop_cnt), 64'd0);

    // a0 held at zero is never captured
    for (int i = 0; i < 20; i++) step();
    check("zero_hold_valid", 64'(trace.out_valid), 64'd0);
    check("zero_hold_count", 64'(count), 64'd0);
    check("zero_hold_ovf", 64'(overflow), 64'd0);

    // Table-driven single-cycle behaviour
    for (int i = 0; i < 11; i++) begin
      a0_in = vecs[i].a0;
      trace.out_ready = vecs[i].rdy;
      step();
      check($sformatf("vec%0d_valid", i), 64'(trace.out_valid), 64'(vecs[i].exp_valid));
      check($sformatf("vec%0d_count", i), 64'(count), 64'(vecs[i].exp_count));
      if (vecs[i].exp_valid)
        check($sformatf("vec%0d_data", i), 64'(trace.out_data), 64'(vecs[i].exp_data));
    end

    // Fill with 1..17 while stalled: 17 is dropped
    trace.out_ready = 1'b0;
    for (int v = 1; v <= 17; v++) begin
      a0_in = DW'(v);
      step();
    end
    check("fill_count", 64'(count), 64'd16);
    check("fill_ovf", 64'(overflow), 64'd1);
    check("fill_drop", 64'(drop_cnt), 64'd1);
    check("fill_head", 64'(trace.out_data), 64'd1);

    // Full, pop and capture together: push accepted, no drop
    a0_in = 32'hAA;
    trace.out_ready = 1'b1;
    step();
    check("fullpop_count", 64'(count), 64'd16);
    check("fullpop_drop", 64'(drop_cnt), 64'd1);

    for (int i = 0; i < 15; i++) drain_exp[i] = DW'(i + 2);
    drain_exp[15] = 32'hAA;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("drain%0d", i), 64'(trace.out_data), 64'(drain_exp[i]));
      step();
    end
    check("drained_valid", 64'(trace.out_valid), 64'd0);
    check("drained_count", 64'(count), 64'd0);

    // Refill, take a second drop, then drop with a same-cycle clear
    trace.out_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      a0_in = DW'(32'h100 + i);
      step();
    end
    a0_in = 32'h1FF;
    step();
    check("drop2_cnt", 64'(drop_cnt), 64'd2);
    a0_in = 32'h200;
    clr_ovf = 1'b1;
    step();
    check("clrdrop_ovf", 64'(overflow), 64'd1);
    check("clrdrop_cnt", 64'(drop_cnt), 64'd1);
    step();
    check("clr_ovf", 64'(overflow), 64'd0);
    check("clr_cnt", 64'(drop_cnt), 64'd0);
    check("clr_count", 64'(count), 64'd16);
    clr_ovf = 1'b0;

    // Held data while stalled
    step();
    check("hold_data", 64'(trace.out_data), 64'h100);

    // Drain to 7 entries, then reset asynchronously between edges
    trace.out_ready = 1'b1;
    for (int i = 0; i < 9; i++) step();
    trace.out_ready = 1'b0;
    check("pre_rst_count", 64'(count), 64'd7);
    check("pre_rst_head", 64'(trace.out_data), 64'h109);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_count", 64'(count), 64'd0);
    check("async_rst_valid", 64'(trace.out_valid), 64'd0);

    // Fresh reset; edge 0 is the first rising edge after release
    do_reset();
    for (int e = 0; e <= 10; e++) begin
      a0_in = (e >= 9) ? 32'h22 : ((e >= 4) ? 32'h11 : 32'h0);
      step();
    end
    check("ts_count", 64'(count), 64'd2);
    check("ts_head0", 64'(trace.out_data), 64'h11);
`ifdef A0_TRACE_TIMESTAMP_EN
    check("ts_stamp0", 64'(trace.out_stamp), 64'd4);
`endif
    trace.out_ready = 1'b1;
    step();
    check("ts_head1", 64'(trace.out_data), 64'h22);
`ifdef A0_TRACE_TIMESTAMP_EN
    check("ts_stamp1", 64'(trace.out_stamp), 64'd9);
`endif
    step();
    check("ts_empty", 64'(trace.out_valid), 64'd0);
    trace.out_ready = 1'b0;

    // Changes while capture is disabled are not replayed on re-enable
    cap_en = 1'b0;
    a0_in = 32'h33;
    step();
    a0_in = 32'h44;
    step();
    check("capoff_count", 64'(count), 64'd0);
    cap_en = 1'b1;
    step();
    check("reenable_count", 64'(count), 64'd0);
    a0_in = 32'h55;
    step();
    check("reenable_cap_count", 64'(count), 64'd1);
    check("reenable_cap_data", 64'(trace.out_data), 64'h55);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/a0_trace_buffer.md
Name: a0_trace_buffer

Overview:
- Downstream consumer of the CPU's a0 result register.
- Detects every change of a0 and pushes each new value into a small FIFO.
- The FIFO is drained through a valid/ready interface by a display driver or the testbench scoreboard.
- No a0 update is lost silently: drops are flagged and counted.

Parameters:
DATA_WIDTH, 32, width of a0 and FIFO entries
DEPTH, 16, FIFO entries; must be a power of 2, minimum 2
CNT_WIDTH, 16, width of drop counter (and timestamp when enabled)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
a0_in  input  DATA_WIDTH  a0 from the cpu top
cap_en  input  1  capture enable; 0 suppresses pushes
out_data  output  DATA_WIDTH  head-of-FIFO value (first-word fall-through)
out_valid  output  1  FIFO non-empty
out_ready  input  1  consumer accepts head this cycle
count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: at least one capture was dropped
drop_cnt  output  CNT_WIDTH  number of dropped captures, saturating
clr_ovf  input  1  synchronous clear of overflow and drop_cnt

Behaviour:
- Reset (async, active-high): prev_a0=0, rd_ptr=wr_ptr=0, count=0, out_valid=0, overflow=0, drop_cnt=0. out_data is don't-care while out_valid=0. Reset mid-operation discards all entries immediately.
- Change detect: cap = cap_en && (a0_in != prev_a0), combinational. prev_a0 <= a0_in on every edge, regardless of cap_en. A cap_en=0 window therefore does not replay the change when re-enabled.
- First value after reset: prev_a0=0, so any nonzero a0 is captured; a0 staying 0 is never captured.
- pop = out_valid && out_ready.
- push = cap && (count<DEPTH || pop).
- drop = cap && !push.
- Latency: a0_in changed before edge k → entry written at edge k → out_valid=1 and out_data=value after edge k.
- Storage: array indexed by ptrs of $clog2(DEPTH) bits; pointers wrap modulo DEPTH. out_data = mem[rd_ptr], combinational from registered storage.
- count: +1 on push only, −1 on pop only, unchanged on push&&pop.
- Full (count=DEPTH) with pop and cap in the same cycle: the push is accepted, no drop, count stays DEPTH.
- Empty with cap: no pop is possible that cycle (out_valid=0); count becomes 1.
- Drop: overflow<=1; drop_cnt<=drop_cnt+1, saturating at 2^CNT_WIDTH−1. The dropped value is discarded; prev_a0 still updates.
- clr_ovf: overflow<=0, drop_cnt<=0.
- clr_ovf and drop in the same cycle: drop wins, giving overflow=1 and drop_cnt=1.
- out_ready while empty has no effect.
- Held data: out_data is stable while out_valid && !out_ready.
- Output timing: all outputs are registered or derived from registers only; there is no combinational path from a0_in to out_valid.

Optional Feature:
Macro A0_TRACE_TIMESTAMP_EN.
- Defined:
  - Adds output out_stamp [CNT_WIDTH-1:0].
  - A free-running cycle counter resets to 0, increments every edge and wraps.
  - Each push stores the counter value sampled at the push edge alongside the data.
  - out_stamp shows the head entry's stamp with the same timing as out_data.
- Undefined: no out_stamp port, no counter, no stamp storage; behaviour otherwise identical.

Test Plan:
- Reset, cap_en=1, a0_in held at 0 for 20 cycles → out_valid stays 0, count=0, overflow=0.
- a0_in changes to 0x0000_0005 before edge 3, out_ready=0 → out_valid=1 after edge 3, out_data=0x5, count=1. out_ready=1 one cycle → out_valid=0, count=0.
- out_ready=0, a0_in steps 1,2,…,17 on consecutive cycles (DEPTH=16) → count=16, overflow=1, drop_cnt=1. Draining yields 1..16 in order, and value 17 is absent.
- FIFO full, out_ready=1 and a0_in changes to 0xAA in the same cycle → no drop, count stays 16, 0xAA is the last entry drained.
- Drop and clr_ovf in the same cycle → overflow=1, drop_cnt=1. Next cycle clr_ovf alone → 0/0. Assert rst mid-stream with count=7 → count=0 and out_valid=0 immediately, without waiting for a clock edge.
- With A0_TRACE_TIMESTAMP_EN, changes at edges 4 and 9 after reset → out_stamp reads 4 then 9 (counter is 0 at the first edge after reset release). Changes of a0_in while cap_en=0 → no entries, and re-enabling does not capture the old change.
